fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage for the SOIN-RV core; replaces the free-running PC counter.
//  Owns the PC: byte addressing, programmable reset vector, branch/jump redirect, fetch-stall input.
//  Drives the combinational-read instruction memory and buffers {pc, instr} pairs in a small FIFO.
//  The FIFO feeds decode over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH    32  instruction width
//  ADDR_WIDTH    32  PC / IM address width
//  PC_STEP       4   PC increment per fetch; power of 2, >=1
//  FIFO_DEPTH    2   fetch-buffer entries; power of 2, >=2
//  RESET_VECTOR  0   PC value loaded on reset
// PORTS
//  i_clk         in   1           clock, rising edge
//  i_rst_n       in   1           synchronous reset, active-low
//  o_ImAddr      out  ADDR_WIDTH  IM read address (= PC register)
//  i_ImInstr     in   DATA_WIDTH  IM read data, same-cycle combinational
//  i_ImStall     in   1           IM not ready: no fetch this cycle
//  i_Redirect    in   1           branch/jump taken: flush and reload PC
//  i_RedirectPc  in   ADDR_WIDTH  redirect target
//  o_Valid       out  1           head entry valid to decode
//  i_Ready       in   1           decode accepts head entry
//  o_Instr       out  DATA_WIDTH  head instruction
//  o_Pc          out  ADDR_WIDTH  head instruction address
//  o_FetchCount  out  32          fetched-instruction counter (see CONFIGURATION)
//  o_StallCount  out  32          stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (i_rst_n=0 at posedge): pc<=RESET_VECTOR, FIFO empty, o_Valid=0, counters=0.
//    o_Instr/o_Pc=0 while empty. Reset overrides every other input.
//  - pop  = o_Valid & i_Ready.
//  - push = ~i_Redirect & ~i_ImStall & (count<FIFO_DEPTH | pop).
//  - On push: entry {pc, i_ImInstr} written at tail; pc <= pc+PC_STEP.
//  - PC arithmetic is mod 2^ADDR_WIDTH: all-ones region wraps to 0 silently.
//  - No push: pc holds.
//  - Latency: instruction presented on o_ImAddr in cycle N is visible on o_Valid/o_Instr
//    in cycle N+1 at the earliest (registered FIFO, no bypass).
//  - Throughput: one instruction/cycle with i_Ready held high.
//  - Full + pop in the same cycle: push allowed; count unchanged.
//  - Empty: o_Valid=0; pop impossible.
//  - Redirect has highest priority (below reset):
//    - FIFO cleared; any simultaneous pop is still consumed by decode, but nothing is pushed.
//    - pc <= i_RedirectPc with low log2(PC_STEP) bits forced to 0.
//    - o_Valid=0 in the cycle after a redirect.
//    - First post-redirect instruction is valid 2 cycles after the redirect edge.
//  - Redirect and i_ImStall together: redirect wins; stall only suppresses the next fetch.
//  - o_Instr/o_Pc hold stable while o_Valid=1 and i_Ready=0.
//  - FIFO pointers are log2(FIFO_DEPTH) bits wide, wrap naturally.
//  - count is log2(FIFO_DEPTH)+1 bits wide.
// CONFIGURATION
//  SOIN_FETCH_PERF_EN defined:
//    - o_FetchCount increments on every push.
//    - o_StallCount increments on every cycle with i_ImStall=1, or with FIFO full and no pop.
//    - Both wrap at 2^32; neither is cleared by redirect.
//  SOIN_FETCH_PERF_EN undefined: counter logic not built, o_FetchCount=o_StallCount=0 constant.
// TESTING
//  1 Reset: RESET_VECTOR=0x100, hold i_rst_n=0 two cycles -> o_ImAddr=0x100, o_Valid=0;
//    release -> o_Pc=0x100 next cycle.
//  2 Streaming: i_Ready=1, IM returns addr-based words -> o_Pc=0x100,0x104,0x108 on consecutive
//    cycles; o_Instr matches.
//  3 Backpressure: i_Ready=0 for 5 cycles -> FIFO fills at 2 entries, o_ImAddr frozen at 0x108,
//    head stable at 0x100.
//  4 Redirect while full, i_Ready=1, i_RedirectPc=0x203 -> next cycle o_Valid=0,
//    o_ImAddr=0x200; following cycle o_Pc=0x200.
//  5 i_ImStall=1 for 3 cycles, FIFO empty -> o_Valid=0, pc holds;
//    with SOIN_FETCH_PERF_EN: o_StallCount +3, o_FetchCount unchanged.
//  6 Wrap: ADDR_WIDTH=8, redirect to 0xFC -> fetch order 0xFC, 0x00, 0x04.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage for the SOIN-RV core. This block owns the program
// counter. It reads the combinational instruction memory at the PC and buffers
// {pc, instr} pairs in a small registered FIFO that feeds decode.
//
// Optional feature macro: SOIN_FETCH_PERF_EN
//   defined   : o_FetchCount counts pushes. o_StallCount counts cycles with
//               i_ImStall=1, and cycles where the FIFO is full and nothing pops.
//               Both counters wrap at 2^32. A redirect does not clear them.
//   undefined : no counter logic is built, and both outputs are constant 0.
//
// Parameters
//   DATA_WIDTH    instruction width
//   ADDR_WIDTH    PC / instruction-memory address width
//   PC_STEP       PC increment per fetch (power of 2, >= 1)
//   FIFO_DEPTH    fetch-buffer entries (power of 2, >= 2)
//   RESET_VECTOR  PC value loaded on reset
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       synchronous reset, active-low, overrides every other input
//   o_ImAddr      instruction-memory read address (the PC register)
//   i_ImInstr     instruction-memory read data, same-cycle combinational
//   i_ImStall     memory not ready: no fetch this cycle
//   i_Redirect    branch/jump taken: flush the buffer and reload the PC
//   i_RedirectPc  redirect target (low log2(PC_STEP) bits are ignored)
//   o_Valid       head entry valid to decode
//   i_Ready       decode accepts the head entry
//   o_Instr       head instruction (0 while the buffer is empty)
//   o_Pc          head instruction address (0 while the buffer is empty)
//   o_FetchCount  fetched-instruction counter
//   o_StallCount  stall-cycle counter
//
// Handshake: the head entry transfers on every rising edge where
// o_Valid and i_Ready are both 1. o_Valid never depends on i_Ready.
// o_Instr and o_Pc hold stable while o_Valid=1 and i_Ready=0.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned PC_STEP      = 4,
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   output logic [ADDR_WIDTH-1:0] o_ImAddr,
   input  logic [DATA_WIDTH-1:0] i_ImInstr,
   input  logic                  i_ImStall,
   input  logic                  i_Redirect,
   input  logic [ADDR_WIDTH-1:0] i_RedirectPc,
   output logic                  o_Valid,
   input  logic                  i_Ready,
   output logic [DATA_WIDTH-1:0] o_Instr,
   output logic [ADDR_WIDTH-1:0] o_Pc,
   output logic [31:0]           o_FetchCount,
   output logic [31:0]           o_StallCount
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] STEP_C    = ADDR_WIDTH'(PC_STEP);
   // Clears the sub-step bits of a redirect target so the PC stays aligned.
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~(ADDR_WIDTH'(PC_STEP - 1));

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] pc;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;

   logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];

   // ---------------------------------------------------------------------------
   // Handshake and control
   // ---------------------------------------------------------------------------
   logic valid;
   logic full;
   logic pop;
   logic push;

   assign valid = (count != '0);
   assign full  = (count == DEPTH_C);
   assign pop   = valid & i_Ready;
   // When the buffer is full, a pop in the same cycle frees the slot the push uses.
   assign push  = ~i_Redirect & ~i_ImStall & (~full | pop);

   assign o_ImAddr = pc;
   assign o_Valid  = valid;
   assign o_Instr  = valid ? instr_mem[rd_ptr] : '0;
   assign o_Pc     = valid ? pc_mem[rd_ptr]    : '0;

   // ---------------------------------------------------------------------------
   // PC register
   // ---------------------------------------------------------------------------
   // A redirect outranks stall and push. The PC wraps modulo 2^ADDR_WIDTH.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pc <= RESET_VECTOR;
      end else if (i_Redirect) begin
         pc <= i_RedirectPc & ALIGN_MSK;
      end else if (push) begin
         pc <= pc + STEP_C;
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO pointers and occupancy
   // ---------------------------------------------------------------------------
   // A redirect empties the buffer. Any pop in that same cycle has already been
   // taken by decode, so the emptied state accounts for it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_Redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO storage: no reset needed, because entries are only read while counted
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= i_ImInstr;
         pc_mem[wr_ptr]    <= pc;
      end
   end

   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
`ifdef SOIN_FETCH_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
   logic        stall_cycle;

   assign stall_cycle = i_ImStall | (full & ~pop);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (push) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (stall_cycle) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end

   assign o_FetchCount = fetch_count;
   assign o_StallCount = stall_count;
`else
   assign o_FetchCount = '0;
   assign o_StallCount = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The main instance uses a 32-bit address and
// RESET_VECTOR=0x100. A second instance uses an 8-bit address to exercise PC
// wrap. Each instruction memory returns a word built from its address, so
// every expected value below is written out by hand.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Main DUT (32-bit address)
   // ---------------------------------------------------------------------------
   logic [31:0] im_addr;
   logic [31:0] im_instr;
   logic        im_stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        valid;
   logic        ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   assign im_instr = {16'hC0DE, im_addr[15:0]};

   fetch_unit #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .PC_STEP     (4),
      .FIFO_DEPTH  (2),
      .RESET_VECTOR(32'h0000_0100)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .o_ImAddr    (im_addr),
      .i_ImInstr   (im_instr),
      .i_ImStall   (im_stall),
      .i_Redirect  (redirect),
      .i_RedirectPc(redirect_pc),
      .o_Valid     (valid),
      .i_Ready     (ready),
      .o_Instr     (instr),
      .o_Pc        (pc),
      .o_FetchCount(fetch_count),
      .o_StallCount(stall_count)
   );

   // ---------------------------------------------------------------------------
   // Second DUT (8-bit address, wrap test)
   // ---------------------------------------------------------------------------
   logic [7:0]  im_addr8;
   logic [31:0] im_instr8;
   logic        redirect8;
   logic [7:0]  redirect_pc8;
   logic        valid8;
   logic        ready8;
   logic [31:0] instr8;
   logic [7:0]  pc8;
   logic [31:0] fetch_count8;
   logic [31:0] stall_count8;

   assign im_instr8 = {24'h5A5A5A, im_addr8};

   fetch_unit #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (8),
      .PC_STEP     (4),
      .FIFO_DEPTH  (2),
      .RESET_VECTOR(8'h00)
   ) dut8 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .o_ImAddr    (im_addr8),
      .i_ImInstr   (im_instr8),
      .i_ImStall   (1'b0),
      .i_Redirect  (redirect8),
      .i_RedirectPc(redirect_pc8),
      .o_Valid     (valid8),
      .i_Ready     (ready8),
      .o_Instr     (instr8),
      .o_Pc        (pc8),
      .o_FetchCount(fetch_count8),
      .o_StallCount(stall_count8)
   );

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock. Sampling happens 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_addr);
      check({tag, ".valid"}, {31'd0, valid}, 32'd1);
      check({tag, ".pc"},    pc,             exp_pc);
      check({tag, ".instr"}, instr,          {16'hC0DE, exp_pc[15:0]});
      check({tag, ".imaddr"}, im_addr,       exp_addr);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst_n        = 1'b0;
      im_stall     = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = '0;
      ready        = 1'b0;
      redirect8    = 1'b0;
      redirect_pc8 = '0;
      ready8       = 1'b0;

      // Reset held for two edges
      tick();
      tick();
      check("rst.imaddr", im_addr, 32'h0000_0100);
      check("rst.valid",  {31'd0, valid}, 32'd0);
      check("rst.pc",     pc,    32'd0);
      check("rst.instr",  instr, 32'd0);
      check("rst.fcnt",   fetch_count, 32'd0);
      check("rst.scnt",   stall_count, 32'd0);

      // Streaming: one instruction per cycle
      rst_n = 1'b1;
      ready = 1'b1;
      tick();
      check_head("stream0", 32'h100, 32'h104);
      tick();
      check_head("stream1", 32'h104, 32'h108);
      tick();
      check_head("stream2", 32'h108, 32'h10C);

      // Restart at 0x100 with decode stalled
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      ready       = 1'b0;
      tick();
      redirect = 1'b0;
      check("bp.flush.valid", {31'd0, valid}, 32'd0);
      check("bp.flush.imaddr", im_addr, 32'h100);
      tick();
      check_head("bp.first", 32'h100, 32'h104);
      tick();
      check_head("bp.fill", 32'h100, 32'h108);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_head("bp.hold", 32'h100, 32'h108);
      end

      // Full + pop in the same cycle: the push still happens
      ready = 1'b1;
      tick();
      check_head("fullpop", 32'h104, 32'h10C);

      // Redirect while full, with decode ready
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect = 1'b0;
      check("redir.valid",  {31'd0, valid}, 32'd0);
      check("redir.imaddr", im_addr, 32'h200);
      check("redir.pc",     pc, 32'd0);
      tick();
      check_head("redir.first", 32'h200, 32'h204);

      // Fetch stall: the first cycle drains the buffer, then 3 cycles stay empty
      im_stall = 1'b1;
      tick();
      check("stall.drain.valid", {31'd0, valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall.valid",  {31'd0, valid}, 32'd0);
         check("stall.imaddr", im_addr, 32'h204);
      end
      im_stall = 1'b0;

`ifdef SOIN_FETCH_PERF_EN
      // Pushes: 3 streaming, 2 fill, 1 full+pop, 1 post-redirect = 7.
      // Stall cycles: 5 full without pop, 1 drain, 3 stalled = 9.
      check("perf.fcnt", fetch_count, 32'd7);
      check("perf.scnt", stall_count, 32'd9);
`else
      check("perf.fcnt", fetch_count, 32'd0);
      check("perf.scnt", stall_count, 32'd0);
`endif

      // Wrap on the 8-bit instance. Target 0xFE aligns to 0xFC.
      redirect8    = 1'b1;
      redirect_pc8 = 8'hFE;
      ready8       = 1'b1;
      tick();
      redirect8 = 1'b0;
      check("wrap.flush.valid",  {31'd0, valid8}, 32'd0);
      check("wrap.flush.imaddr", {24'd0, im_addr8}, 32'h0000_00FC);
      tick();
      check("wrap0.pc",    {24'd0, pc8}, 32'h0000_00FC);
      check("wrap0.instr", instr8, 32'h5A5A_5AFC);
      check("wrap0.imaddr", {24'd0, im_addr8}, 32'h0000_0000);
      tick();
      check("wrap1.pc",    {24'd0, pc8}, 32'h0000_0000);
      check("wrap1.instr", instr8, 32'h5A5A_5A00);
      tick();
      check("wrap2.pc",    {24'd0, pc8}, 32'h0000_0004);
      check("wrap2.instr", instr8, 32'h5A5A_5A04);
      check("wrap2.valid", {31'd0, valid8}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
